// File: rtl/multitap_delay_line.sv
// multitap_delay_line: circular-buffer delay line for echo/chorus voices.
// Each accepted sample is written at wr_ptr, then NUM_TAPS past samples are
// read one per cycle at (wr_ptr - delay[i]) and returned together on tap_out.
// Optional feature: define MULTITAP_DELAY_LINE_MEM_CLEAR_EN to sweep the
// buffer to zero after every sclr (busy stays high for DEPTH cycles).
module multitap_delay_line #(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 4096,
    parameter int NUM_TAPS = 4,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         sclr,
    input  logic                         sample_en,
    input  logic [WIDTH-1:0]             in,
    input  logic [NUM_TAPS*ADDR_W-1:0]   delay,
    output logic                         busy,
    output logic [NUM_TAPS*WIDTH-1:0]    tap_out,
    output logic                         out_valid,
    output logic                         overrun
);

    localparam int            K_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, READ, DONE, CLEAR} state_t;

`ifdef MULTITAP_DELAY_LINE_MEM_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_addr;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                     state, state_nxt;
    logic [K_W-1:0]             k;          // tap currently being addressed
    logic [NUM_TAPS*ADDR_W-1:0] delay_q;    // delays latched at acceptance
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          rd_addr;
    logic [WIDTH-1:0]           rd_data;
    logic                       rd_pend;    // rd_data holds a tap to capture
    logic [K_W-1:0]             rd_idx;     // slot that rd_data belongs to
    logic                       accept;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [WIDTH-1:0]           mem_wdata;

    logic [WIDTH-1:0] mem [DEPTH];

    // State register; reset wins over everything else.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (sclr) state <= RST_STATE;
        else      state <= state_nxt;
    end

    // Next-state logic: IDLE -> READ (NUM_TAPS cycles) -> DONE -> IDLE.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (k == K_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
`ifdef MULTITAP_DELAY_LINE_MEM_CLEAR_EN
            CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode: busy covers the out_valid cycle so the next
    // sample is accepted one cycle after the result is presented.
    always_comb begin
        busy      = (state != IDLE) || out_valid;
        accept    = sample_en && !busy && !sclr;
        rd_addr   = wr_ptr - delay_q[k*ADDR_W +: ADDR_W];
        mem_we    = accept;
        mem_waddr = wr_ptr;
        mem_wdata = in;
`ifdef MULTITAP_DELAY_LINE_MEM_CLEAR_EN
        if (state == CLEAR && !sclr) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    // Buffer write port and synchronous read port (read-through-write comes
    // for free: the write lands one edge before the first read).
    // NOTE: the buffer and its read register have no reset so they map onto
    // block RAM; clearing, when wanted, is an explicit sweep.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (state == READ) rd_data <= mem[rd_addr];
    end

    // Sequencing datapath: tap index, pointer, tap capture and status flags.
    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr    <= '0;
            k         <= '0;
            delay_q   <= '0;
            rd_pend   <= 1'b0;
            rd_idx    <= '0;
            tap_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef MULTITAP_DELAY_LINE_MEM_CLEAR_EN
            clr_addr  <= '0;
`endif
        end else begin
            out_valid <= (state == DONE);
            rd_pend   <= (state == READ);
            rd_idx    <= k;
            if (sample_en && busy) overrun <= 1'b1;
            if (accept) begin
                delay_q <= delay;
                k       <= '0;
            end
            if (state == READ) k <= (k == K_LAST) ? '0 : k + K_W'(1);
            if (rd_pend) tap_out[rd_idx*WIDTH +: WIDTH] <= rd_data;
            if (state == DONE) wr_ptr <= wr_ptr + ADDR_W'(1);
`ifdef MULTITAP_DELAY_LINE_MEM_CLEAR_EN
            if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
`endif
        end
    end

endmodule
